counter_countdown: RTL and testbench
====================================

// Module: counter_countdown
// PURPOSE
//   Modulo-MAX down counter: the decrementing counterpart of the up counter.
//   Used for countdown timers, remaining-beat counts and reverse address walks.
//   Counts MAX-1..0, wraps 0 -> MAX-1 and flags the wrap with a one-cycle borrow.
//   All outputs pass through the shared DELAY-stage delay line, aligned with each other.
// PARAMETERS
//   MAX    16                 modulus; legal count values 0..MAX-1; MAX >= 2
//   WIDTH  Util_Math_log2(MAX) counter width in bits
//   DELAY  0                  output pipeline stages on q/zero/borrow; 0 = direct
// PORTS
//   ctrl     input   Data_Control_T  control bundle; clock and reset fields below
//                                    clock = Data_Control_Clock(ctrl), rising edge
//                                    reset = Data_Control_Reset(ctrl), synchronous, active-high
//   d        input   WIDTH           load value
//   load     input   1               load d this cycle
//   enable   input   1               decrement this cycle
//   q        output  WIDTH           count value, after DELAY stages
//   zero     output  1               q == 0, aligned with q
//   borrow   output  1               one-cycle wrap flag, aligned with q
//   reload_d  input  WIDTH           [RELOAD_EN only] reload value
//   reload_we input  1               [RELOAD_EN only] write reload_d
// BEHAVIOUR
//   - Internal state: count register c and borrow register b. Both are registered.
//     zero is derived from c (c == 0). All three pass through the same DELAY line.
//   - Priority on each clock edge: reset > load > enable > hold.
//   - reset: c <= 0, b <= 0, every delay stage <= {0, zero=1, borrow=0}.
//     Outputs after reset: q=0, zero=1, borrow=0. Reset mid-count discards all state.
//   - load: c <= (d >= MAX) ? MAX-1 : d (clamped). b <= 0. enable is ignored.
//   - enable with c != 0: c <= c - 1, b <= 0.
//   - enable with c == 0: c <= wrap value, b <= 1. borrow is high in the same cycle
//     that q shows the wrap value, for one cycle only.
//     Wrap value is MAX-1, or the reload register when RELOAD_EN is defined.
//   - Hold (neither load nor enable): c unchanged, b <= 0.
//   - MAX == 2**WIDTH: natural underflow gives the same wrap value; no compare is needed.
//   - Latency: the change is visible on q DELAY+1 edges after the controlling input edge.
//     With DELAY=0, q equals c.
//   - The subtraction is WIDTH bits wide; the wrap is detected on c == 0, never on carry-out.
// CONFIGURATION
//   COUNTER_COUNTDOWN_RELOAD_EN defined:
//     - Adds the reload_d and reload_we ports and a WIDTH-bit reload register r.
//     - reset: r <= MAX-1.
//     - reload_we: r <= (reload_d >= MAX) ? MAX-1 : reload_d.
//     - The wrap loads c <= r. If reload_we and the wrap fall in the same cycle,
//       the wrap uses the old r.
//     - reload_we alone does not change c. load still uses d.
//   COUNTER_COUNTDOWN_RELOAD_EN undefined:
//     - The reload ports and register do not exist; the wrap value is always MAX-1.
// TESTING
//   1. MAX=10, DELAY=0: hold reset 2 cycles -> q=0, zero=1, borrow=0.
//   2. MAX=10: load d=3, then enable for 5 cycles
//      -> q=3,2,1,0,9,8; zero only at q=0; borrow only at q=9.
//   3. MAX=10: load d=12 -> q=9. load d=9 -> q=9. load and enable together, d=5
//      -> q=5, borrow=0.
//   4. MAX=16: from q=0, enable -> q=15, borrow=1; next cycle with enable=0
//      -> q=15, borrow=0.
//   5. MAX=10, DELAY=2: load 4, enable -> q shows 4 after 3 edges and 3 after 4 edges.
//      Assert reset mid-run -> q=0 and zero=1 in all stages on the next edge.
//   6. RELOAD_EN, MAX=10: reload_we with reload_d=4, count 1 -> 0 -> 4 with borrow=1.
//      reload_we with 7 during the wrap cycle -> wrap gives 4, next wrap gives 7.

Source files
------------

// File: rtl/counter_countdown.sv
// Modulo-MAX down counter with one-cycle wrap borrow and an aligned DELAY-stage output line.
// Optional reload register for the wrap value: define COUNTER_COUNTDOWN_RELOAD_EN.
module counter_countdown #(
  parameter int MAX   = 16,
  parameter int WIDTH = $clog2(MAX),
  parameter int DELAY = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_load,
  input  logic             i_enable,
`ifdef COUNTER_COUNTDOWN_RELOAD_EN
  input  logic [WIDTH-1:0] i_reload_d,
  input  logic             i_reload_we,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero,
  output logic             o_borrow
);

  localparam logic [WIDTH-1:0] LP_TOP = WIDTH'(MAX - 1);

  // A full power-of-two modulus never sees an out-of-range value, so no compare is built.
  function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v);
    if (MAX == (2 ** WIDTH)) return v;
    return ({1'b0, v} >= (WIDTH + 1)'(MAX)) ? LP_TOP : v;
  endfunction

  logic [WIDTH-1:0] r_c;
  logic             r_b;
  logic [WIDTH-1:0] w_wrap;
  logic             w_zero;

`ifdef COUNTER_COUNTDOWN_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  // The wrap in the same cycle as a reload write still sees the old value.
  always_ff @(posedge i_clk) begin
    if (i_rst)            r_reload <= LP_TOP;
    else if (i_reload_we) r_reload <= f_clamp(i_reload_d);
  end

  assign w_wrap = r_reload;
`else
  assign w_wrap = LP_TOP;
`endif

  assign w_zero = (r_c == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c <= '0;
      r_b <= 1'b0;
    end else if (i_load) begin
      r_c <= f_clamp(i_d);
      r_b <= 1'b0;
    end else if (i_enable) begin
      if (w_zero) begin
        r_c <= w_wrap;
        r_b <= 1'b1;
      end else begin
        r_c <= r_c - WIDTH'(1);
        r_b <= 1'b0;
      end
    end else begin
      r_b <= 1'b0;
    end
  end

  generate
    if (DELAY == 0) begin : g_direct
      assign o_q      = r_c;
      assign o_zero   = w_zero;
      assign o_borrow = r_b;
    end else begin : g_delay
      logic [WIDTH-1:0] r_dq [DELAY];
      logic             r_dz [DELAY];
      logic             r_db [DELAY];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DELAY; i++) begin
            r_dq[i] <= '0;
            r_dz[i] <= 1'b1;
            r_db[i] <= 1'b0;
          end
        end else begin
          r_dq[0] <= r_c;
          r_dz[0] <= w_zero;
          r_db[0] <= r_b;
          for (int i = 1; i < DELAY; i++) begin
            r_dq[i] <= r_dq[i-1];
            r_dz[i] <= r_dz[i-1];
            r_db[i] <= r_db[i-1];
          end
        end
      end

      assign o_q      = r_dq[DELAY-1];
      assign o_zero   = r_dz[DELAY-1];
      assign o_borrow = r_db[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_counter_countdown.sv
// Drives three counter_countdown builds (MAX/DELAY = 10/0, 16/0, 10/2) from shared inputs
// and compares each against an arithmetic model of the counting rules.
module tb_counter_countdown;

  localparam int MX [3] = '{10, 16, 10};
  localparam int DL [3] = '{0, 0, 2};
`ifdef COUNTER_COUNTDOWN_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d = '0;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [3:0] rd = '0;
  logic       rwe = 1'b0;
  logic [3:0] oq [3];
  logic       oz [3];
  logic       ob [3];

  int n_assert = 0;
  int n_fail = 0;

  // Model state: count, borrow, reload value, and the last two (count, borrow) pairs.
  int mc [3];
  int mb [3];
  int mr [3];
  int hc [3][2];
  int hb [3][2];

  always #5 clk = ~clk;

`ifdef COUNTER_COUNTDOWN_RELOAD_EN
  counter_countdown #(.MAX(10), .DELAY(0)) u_a (.i_clk(clk), .i_rst(rst), .i_d(d), .i_load(load),
    .i_enable(en), .i_reload_d(rd), .i_reload_we(rwe), .o_q(oq[0]), .o_zero(oz[0]), .o_borrow(ob[0]));
  counter_countdown #(.MAX(16), .DELAY(0)) u_b (.i_clk(clk), .i_rst(rst), .i_d(d), .i_load(load),
    .i_enable(en), .i_reload_d(rd), .i_reload_we(rwe), .o_q(oq[1]), .o_zero(oz[1]), .o_borrow(ob[1]));
  counter_countdown #(.MAX(10), .DELAY(2)) u_c (.i_clk(clk), .i_rst(rst), .i_d(d), .i_load(load),
    .i_enable(en), .i_reload_d(rd), .i_reload_we(rwe), .o_q(oq[2]), .o_zero(oz[2]), .o_borrow(ob[2]));
`else
  counter_countdown #(.MAX(10), .DELAY(0)) u_a (.i_clk(clk), .i_rst(rst), .i_d(d), .i_load(load),
    .i_enable(en), .o_q(oq[0]), .o_zero(oz[0]), .o_borrow(ob[0]));
  counter_countdown #(.MAX(16), .DELAY(0)) u_b (.i_clk(clk), .i_rst(rst), .i_d(d), .i_load(load),
    .i_enable(en), .o_q(oq[1]), .o_zero(oz[1]), .o_borrow(ob[1]));
  counter_countdown #(.MAX(10), .DELAY(2)) u_c (.i_clk(clk), .i_rst(rst), .i_d(d), .i_load(load),
    .i_enable(en), .o_q(oq[2]), .o_zero(oz[2]), .o_borrow(ob[2]));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lim(input int v, input int mx);
    return (v >= mx) ? mx - 1 : v;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mc[k] = 0; mb[k] = 0; mr[k] = MX[k] - 1;
        for (int j = 0; j < 2; j++) begin hc[k][j] = 0; hb[k][j] = 0; end
      end else begin
        hc[k][1] = hc[k][0]; hb[k][1] = hb[k][0];
        hc[k][0] = mc[k];    hb[k][0] = mb[k];
        if (load) begin
          mc[k] = lim(int'(d), MX[k]); mb[k] = 0;
        end else if (en) begin
          if (mc[k] == 0) begin
            mc[k] = RL ? mr[k] : MX[k] - 1; mb[k] = 1;
          end else begin
            mc[k] = mc[k] - 1; mb[k] = 0;
          end
        end else begin
          mb[k] = 0;
        end
        if (RL && rwe) mr[k] = lim(int'(rd), MX[k]);
      end
    end
  endtask

  task automatic check_all();
    int eq, eb;
    for (int k = 0; k < 3; k++) begin
      eq = (DL[k] == 0) ? mc[k] : hc[k][DL[k]-1];
      eb = (DL[k] == 0) ? mb[k] : hb[k][DL[k]-1];
      chk($sformatf("dut%0d.q", k), 32'(oq[k]), 32'(eq));
      chk($sformatf("dut%0d.zero", k), 32'(oz[k]), 32'(eq == 0));
      chk($sformatf("dut%0d.borrow", k), 32'(ob[k]), 32'(eb));
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic e, input int dv,
                     input logic we = 1'b0, input int rdv = 0);
    rst = r; load = l; en = e; d = 4'(dv); rwe = we; rd = 4'(rdv);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int seq [5];
    seq = '{2, 1, 0, 9, 8};

    // Reset held two cycles.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset.q", 32'(oq[0]), 32'd0);
    chk("reset.zero", 32'(oz[0]), 32'd1);
    chk("reset.borrow", 32'(ob[0]), 32'd0);
    chk("reset.c_zero", 32'(oz[2]), 32'd1);

    // Load 3 and count through the wrap.
    cyc(0, 1, 0, 3);
    chk("load3.q", 32'(oq[0]), 32'd3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("down%0d.q", i), 32'(oq[0]), 32'(seq[i]));
      chk($sformatf("down%0d.zero", i), 32'(oz[0]), 32'(seq[i] == 0));
      chk($sformatf("down%0d.borrow", i), 32'(ob[0]), 32'(seq[i] == 9));
    end

    // Clamped loads and load-over-enable priority.
    cyc(0, 1, 0, 12);
    chk("load12.q", 32'(oq[0]), 32'd9);
    cyc(0, 1, 0, 9);
    chk("load9.q", 32'(oq[0]), 32'd9);
    cyc(0, 1, 1, 5);
    chk("load_en.q", 32'(oq[0]), 32'd5);
    chk("load_en.borrow", 32'(ob[0]), 32'd0);

    // Power-of-two modulus wrap, borrow lasts one cycle.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("m16wrap.q", 32'(oq[1]), 32'd15);
    chk("m16wrap.borrow", 32'(ob[1]), 32'd1);
    cyc(0, 0, 0, 0);
    chk("m16hold.q", 32'(oq[1]), 32'd15);
    chk("m16hold.borrow", 32'(ob[1]), 32'd0);

    // Delayed build: latency, then reset clears every stage at once.
    cyc(0, 1, 0, 4);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("dly.q_edge3", 32'(oq[2]), 32'd4);
    cyc(0, 0, 1, 0);
    chk("dly.q_edge4", 32'(oq[2]), 32'd3);
    cyc(1, 0, 0, 0);
    chk("dly.rst_q", 32'(oq[2]), 32'd0);
    chk("dly.rst_zero", 32'(oz[2]), 32'd1);
    cyc(0, 0, 0, 0);
    chk("dly.rst_hold_q", 32'(oq[2]), 32'd0);

`ifdef COUNTER_COUNTDOWN_RELOAD_EN
    cyc(0, 0, 0, 0, 1, 4);
    chk("rl.we_no_change", 32'(oq[0]), 32'd0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("rl.wrap4.q", 32'(oq[0]), 32'd4);
    chk("rl.wrap4.borrow", 32'(ob[0]), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 7);
    chk("rl.wrap_old.q", 32'(oq[0]), 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("rl.wrap7.q", 32'(oq[0]), 32'd7);
    chk("rl.wrap7.borrow", 32'(ob[0]), 32'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(39) == 0), ($urandom_range(5) == 0), ($urandom_range(1) == 0),
          int'($urandom_range(15)), ($urandom_range(7) == 0), int'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
